// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared constants for the UART RX path (state codes, defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int c_DATA_WIDTH_DEF     = 8;
    localparam int c_PRESCALE_WIDTH_DEF = 6;
    localparam int c_PRESCALE_RST       = 8;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/edge_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : edge_bit_counter
// Description : Oversample edge counter and bit-slot counter with wrap logic.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_bit_counter #(
    parameter int Prescale_width = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [Prescale_width-1:0] prescale_q,
    output logic [Prescale_width-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      end_of_bit
);

    localparam logic [Prescale_width-1:0] c_EDGE_ONE = {{(Prescale_width-1){1'b0}}, 1'b1};
    localparam logic [BIT_CNT_WIDTH-1:0]  c_BIT_ONE  = {{(BIT_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [Prescale_width-1:0] r_edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  r_bit_cnt;
    logic [Prescale_width-1:0] w_last_edge;

    assign w_last_edge = prescale_q - c_EDGE_ONE;
    assign end_of_bit  = (r_edge_cnt == w_last_edge);
    assign edge_cnt    = r_edge_cnt;
    assign bit_cnt     = r_bit_cnt;

    // Dropping enable clears both counters so the next frame starts at slot 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (!enable) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (end_of_bit) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + c_BIT_ONE;
        end else begin
            r_edge_cnt <= r_edge_cnt + c_EDGE_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive sequencer: start detect, slot enables, frame flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_width     = c_DATA_WIDTH_DEF,
    parameter int Prescale_width = c_PRESCALE_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             RX_IN,
    input  logic [Prescale_width-1:0]        Prescale,
    input  logic                             PAR_EN,
    input  logic                             sampled_bit,
    input  logic                             par_err,
    output logic [Prescale_width-1:0]        edge_cnt,
    output logic [$clog2(DATA_width+3)-1:0]  bit_cnt,
    output logic                             dat_samp_en,
    output logic                             deser_en,
    output logic                             par_chk_en,
    output logic                             data_valid,
    output logic                             par_err_flag,
    output logic                             stp_err_flag,
    output logic                             busy
);

    localparam int c_BIT_CNT_WIDTH = $clog2(DATA_width + 3);
    localparam logic [c_BIT_CNT_WIDTH-1:0] c_LAST_DATA_BIT = c_BIT_CNT_WIDTH'(DATA_width);
    localparam logic [Prescale_width-1:0]  c_PRESCALE_INIT = Prescale_width'(c_PRESCALE_RST);

    logic [2:0]                r_state;
    logic [2:0]                w_next_state;
    logic [Prescale_width-1:0] r_prescale_q;
    logic                      r_par_en;
    logic                      r_data_valid;
    logic                      r_par_err_flag;
    logic                      r_stp_err_flag;
    logic                      w_end_of_bit;
    logic                      w_cnt_enable;
    logic                      w_set_dv;
    logic                      w_set_par;
    logic                      w_set_stp;

    // The counter is released on the frame-ending edge so IDLE always reads zero.
    assign w_cnt_enable = (r_state != c_ST_IDLE) && (w_next_state != c_ST_IDLE);

    edge_bit_counter #(
        .Prescale_width (Prescale_width),
        .BIT_CNT_WIDTH  (c_BIT_CNT_WIDTH)
    ) u_edge_bit_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (w_cnt_enable),
        .prescale_q (r_prescale_q),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .end_of_bit (w_end_of_bit)
    );

    always_comb begin
        w_next_state = r_state;
        w_set_dv     = 1'b0;
        w_set_par    = 1'b0;
        w_set_stp    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!RX_IN) w_next_state = c_ST_START;
            end
            c_ST_START: begin
                if (w_end_of_bit) w_next_state = sampled_bit ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_end_of_bit && (bit_cnt == c_LAST_DATA_BIT))
                    w_next_state = r_par_en ? c_ST_PARITY : c_ST_STOP;
            end
            c_ST_PARITY: begin
                if (w_end_of_bit) begin
                    if (par_err) begin
                        w_next_state = c_ST_IDLE;
                        w_set_par    = 1'b1;
                    end else begin
                        w_next_state = c_ST_STOP;
                    end
                end
            end
            c_ST_STOP: begin
                if (w_end_of_bit) begin
                    w_next_state = c_ST_IDLE;
                    w_set_dv     = sampled_bit;
                    w_set_stp    = !sampled_bit;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= c_ST_IDLE;
            r_prescale_q   <= c_PRESCALE_INIT;
            r_par_en       <= 1'b0;
            r_data_valid   <= 1'b0;
            r_par_err_flag <= 1'b0;
            r_stp_err_flag <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_data_valid   <= w_set_dv;
            r_par_err_flag <= w_set_par;
            r_stp_err_flag <= w_set_stp;
            // Frame configuration is frozen once the start edge is taken.
            if (r_state == c_ST_IDLE) begin
                r_prescale_q <= Prescale;
                if (!RX_IN) r_par_en <= PAR_EN;
            end
        end
    end

    assign busy         = (r_state != c_ST_IDLE);
    assign dat_samp_en  = (r_state != c_ST_IDLE);
    assign deser_en     = (r_state == c_ST_DATA);
    assign par_chk_en   = (r_state == c_ST_PARITY);
    assign data_valid   = r_data_valid;
    assign par_err_flag = r_par_err_flag;
    assign stp_err_flag = r_stp_err_flag;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Directed and randomized frame bench for uart_rx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int W  = 8;
    localparam int PW = 6;
    localparam int BW = $clog2(W + 3);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = 6'd8;
    logic          PAR_EN = 1'b0;
    logic          sampled_bit = 1'b1;
    logic          par_err = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          dat_samp_en, deser_en, par_chk_en;
    logic          data_valid, par_err_flag, stp_err_flag, busy;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ctrl #(.DATA_width(W), .Prescale_width(PW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .sampled_bit  (sampled_bit),
        .par_err      (par_err),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .dat_samp_en  (dat_samp_en),
        .deser_en     (deser_en),
        .par_chk_en   (par_chk_en),
        .data_valid   (data_valid),
        .par_err_flag (par_err_flag),
        .stp_err_flag (stp_err_flag),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] all_outs();
        return {edge_cnt, bit_cnt, dat_samp_en, deser_en, par_chk_en,
                data_valid, par_err_flag, stp_err_flag, busy};
    endfunction

    // Drives one frame starting in the current IDLE cycle; the frame's outcome,
    // slot timing and enable windows are derived from the frame description only.
    task automatic run_frame(input int p, input bit pen, input logic [7:0] data,
                             input bit bad_par, input bit stop_v, input int mid_p,
                             output int dv_cyc);
        logic       line[$];
        logic [7:0] shreg;
        int         par_slot, end_slots, last;
        int         track_bad, n_deser, n_par, n_busy, n_spur;
        bit         exp_dv, exp_pe, exp_se;
        line = {};
        line.push_back(1'b0);
        for (int i = 0; i < 8; i++) line.push_back(data[i]);
        par_slot = -1;
        if (pen) begin
            par_slot = line.size();
            line.push_back(^data);
        end
        line.push_back(stop_v);
        exp_pe    = pen && bad_par;
        exp_dv    = !exp_pe && stop_v;
        exp_se    = !exp_pe && !stop_v;
        end_slots = exp_pe ? par_slot + 1 : line.size();
        last      = end_slots * p + 1;
        shreg = '0; track_bad = 0; n_deser = 0; n_par = 0; n_busy = 0; n_spur = 0;
        dv_cyc = -1;
        RX_IN = 1'b0; Prescale = PW'(p); PAR_EN = pen; sampled_bit = 1'b0; par_err = 1'b0;
        for (int c = 1; c <= last; c++) begin
            int slot;
            tick();
            slot = (c - 1) / p;
            if (c < last) begin
                if (edge_cnt !== PW'((c - 1) % p) || bit_cnt !== BW'(slot)) track_bad++;
                if (data_valid || par_err_flag || stp_err_flag) n_spur++;
                RX_IN       = line[slot];
                sampled_bit = line[slot];
                par_err     = (slot == par_slot) ? bad_par : 1'b0;
            end else begin
                RX_IN = 1'b1; sampled_bit = 1'b1; par_err = 1'b0;
            end
            n_deser += int'(deser_en);
            n_par   += int'(par_chk_en);
            n_busy  += int'(busy);
            if (deser_en && edge_cnt == PW'(p - 1)) shreg = {sampled_bit, shreg[7:1]};
            if (data_valid) dv_cyc = cyc;
            if (mid_p != 0 && c == 4 * p) begin
                Prescale = PW'(mid_p);
                PAR_EN   = !pen;
            end
        end
        check("counter_tracking", track_bad, 0);
        check("deser_en_cycles", n_deser, 8 * p);
        check("par_chk_en_cycles", n_par, pen ? p : 0);
        check("busy_cycles", n_busy, end_slots * p);
        check("early_flag", n_spur, 0);
        check("data_valid", data_valid, exp_dv);
        check("par_err_flag", par_err_flag, exp_pe);
        check("stp_err_flag", stp_err_flag, exp_se);
        if (exp_dv) check("p_data", shreg, data);
    endtask

    initial begin
        int t1, t2, t3, p, n_busy, n_deser, n_flag;
        logic [7:0] d;

        #1;
        check("reset_outputs", all_outs(), 17'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) tick();
        check("idle_after_reset", all_outs(), 17'd0);

        run_frame(8, 1'b0, 8'h4D, 1'b0, 1'b1, 0, t1);
        run_frame(16, 1'b1, 8'hA5, 1'b0, 1'b1, 0, t1);
        d = 8'($urandom);
        run_frame(8, 1'b1, d, 1'b1, 1'b1, 0, t1);
        check("par_err_no_dv", t1, -1);
        tick();
        check("idle_after_par_err", busy, 1'b0);
        d = 8'($urandom);
        run_frame(8, 1'b0, d, 1'b0, 1'b0, 0, t1);
        d = 8'($urandom);
        run_frame(32, 1'b1, d, 1'b0, 1'b0, 0, t1);

        // Start glitch: line low for two cycles, sampler reports high.
        tick();
        RX_IN = 1'b0; sampled_bit = 1'b1; Prescale = 6'd8;
        n_busy = 0; n_deser = 0; n_flag = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 2) RX_IN = 1'b1;
            n_busy  += int'(busy);
            n_deser += int'(deser_en);
            n_flag  += int'(data_valid) + int'(par_err_flag) + int'(stp_err_flag);
        end
        check("glitch_busy_cycles", n_busy, 8);
        check("glitch_deser", n_deser, 0);
        check("glitch_flags", n_flag, 0);
        check("glitch_idle", busy, 1'b0);

        // Back-to-back frames, with a Prescale/PAR_EN change inside the second.
        tick();
        d = 8'($urandom);
        run_frame(8, 1'b0, d, 1'b0, 1'b1, 0, t1);
        d = 8'($urandom);
        run_frame(8, 1'b0, d, 1'b0, 1'b1, 16, t2);
        d = 8'($urandom);
        run_frame(16, 1'b0, d, 1'b0, 1'b1, 0, t3);
        check("b2b_spacing_p8", t2 - t1, 81);
        check("b2b_spacing_p16", t3 - t2, 161);

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(2, 0))
                0: p = 8;
                1: p = 16;
                default: p = 32;
            endcase
            d = 8'($urandom);
            run_frame(p, 1'($urandom), d, ($urandom_range(3, 0) == 0),
                      ($urandom_range(3, 0) != 0), 0, t1);
        end

        // Reset in the middle of DATA.
        tick();
        RX_IN = 1'b0; Prescale = 6'd8; PAR_EN = 1'b0; sampled_bit = 1'b0;
        repeat (30) tick();
        check("pre_reset_deser", deser_en, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 17'd0);
        RX_IN = 1'b1; sampled_bit = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) tick();
        d = 8'($urandom);
        run_frame(8, 1'b1, d, 1'b0, 1'b1, 0, t1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART RX path. Detects the start edge on the serial line, runs the oversampling edge/bit counters, and enables the data sampler, deserializer and parity checker at the correct bit slots. It validates start and stop bits itself and emits a one-cycle `data_valid` or error pulse per frame. It sits between the raw `RX_IN` pin and the existing `data_sampler` / `deserializer` / `parity_check` blocks, and supplies their `edge_cnt`, `deser_en` and enable inputs.

## Interface
- `DATA_width`, default 8: data bits per frame.
- `Prescale_width`, default 6: width of `Prescale` and `edge_cnt`.
- `clk` input, 1 bit: single clock (oversampling clock).
- `reset_n` input, 1 bit: **asynchronous, active-low** reset.
- `RX_IN` input, 1 bit: serial line, already synchronised upstream; idles high.
- `Prescale` input, `Prescale_width` bits: oversampling ratio; supported values are 8, 16 and 32.
- `PAR_EN` input, 1 bit: parity bit present in the frame.
- `sampled_bit` input, 1 bit: majority-voted bit from `data_sampler`; valid at `edge_cnt == Prescale-1`.
- `par_err` input, 1 bit: parity mismatch from `parity_check`; valid at `edge_cnt == Prescale-1` of the parity slot.
- `edge_cnt` output, `Prescale_width` bits: oversample position within the current bit.
- `bit_cnt` output, `$clog2(DATA_width+3)` bits: bit slot index (0 = start).
- `dat_samp_en` output, 1 bit: sampler enable.
- `deser_en` output, 1 bit: deserializer shift enable.
- `par_chk_en` output, 1 bit: parity checker enable.
- `data_valid` output, 1 bit: frame accepted; `P_DATA` is valid.
- `par_err_flag` output, 1 bit: frame dropped because of a parity error.
- `stp_err_flag` output, 1 bit: frame dropped because of a framing (stop-bit) error.
- `busy` output, 1 bit: a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - Counters are held at 0.
  - `Prescale` is captured into `prescale_q` every IDLE cycle.
  - When `RX_IN == 0` at a clock edge, go to START.
- **Counters** run in every non-IDLE state.
  - `edge_cnt` counts 0..`prescale_q`-1 and then wraps to 0.
  - On each wrap, `bit_cnt` increments.
  - "End of bit" means `edge_cnt == prescale_q-1`.
- **START**, at end of bit:
  - `sampled_bit == 1` (glitch): go to IDLE silently, with no flag.
  - Otherwise go to DATA.
- **DATA**
  - Covers `bit_cnt` 1..`DATA_width`.
  - At end of bit with `bit_cnt == DATA_width`: go to PARITY if `PAR_EN`, else go to STOP.
- **PARITY**, at end of bit:
  - `par_err`: go to IDLE and pulse `par_err_flag`.
  - Otherwise go to STOP.
- **STOP**, at end of bit:
  - `sampled_bit == 1`: pulse `data_valid`.
  - Otherwise pulse `stp_err_flag`.
  - Go to IDLE in both cases.
- Moore decodes, combinational from the state register:
  - `busy` = `dat_samp_en` = (state != IDLE).
  - `deser_en` = (state == DATA).
  - `par_chk_en` = (state == PARITY).
- `data_valid`, `par_err_flag` and `stp_err_flag` are registered. Each is high for exactly one cycle, the first IDLE cycle after the frame. They are mutually exclusive.
- `PAR_EN` and `Prescale` changes while `busy` do not affect the current frame. `PAR_EN` is sampled on the IDLE→START transition.
- Reset (at any time, including mid-frame):
  - State returns to IDLE.
  - `edge_cnt`, `bit_cnt` and all flags go to 0; `prescale_q` goes to 8.
  - All outputs read 0.

## Timing
- Cycle 0: the IDLE edge at which `RX_IN == 0` is seen.
- Cycles 1..P are START, with `edge_cnt` running 0..P-1 and `bit_cnt == 0`.
- DATA occupies `DATA_width*P` cycles. `deser_en` is high continuously for those cycles.
- With parity: STOP ends at cycle `(DATA_width+3)*P`, and `data_valid` is high in cycle `(DATA_width+3)*P + 1`.
  - For P=8, W=8 that is 88 non-IDLE cycles; `data_valid` is high in cycle 89.
- Without parity: 80 non-IDLE cycles; `data_valid` is high in cycle 81.
- Back-to-back frames:
  - A start bit present in the first IDLE cycle after a frame is accepted. This is the cycle in which `data_valid` is high.
  - There is no dead cycle beyond that one.
- A glitch abort returns to IDLE after exactly P START cycles.

## Structure
- The shared `uart_rx_pkg` holds:
  - The state encoding (3 bits): IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - Default `DATA_width` and `Prescale_width`.
  - The reset value of `prescale_q` (8).
- Sub-module `edge_bit_counter` contains `edge_cnt`, `bit_cnt` and the wrap logic.
  - Inputs: `enable` and `prescale_q`.
  - It is reused by the TX side.
- `uart_rx_ctrl` holds the FSM, the `prescale_q` register and the flag registers.

## Test plan
- **Good frame, no parity.** P=8, `PAR_EN=0`, data 0x4D (LSB first).
  - `deser_en` high for exactly 64 cycles.
  - `data_valid` pulses once, at cycle 81.
  - Downstream `P_DATA == 8'h4D`.
- **Good frame, parity.** P=16, `PAR_EN=1`, data 0xA5, correct parity, `par_err=0`.
  - `par_chk_en` high for 16 cycles.
  - `data_valid` pulses at cycle 177.
- **Errors.**
  - Parity error: `par_err=1` at the end of the parity bit gives an `par_err_flag` pulse, no `data_valid`, and a return to IDLE.
  - Framing error: stop bit 0 gives an `stp_err_flag` pulse only.
- **Start glitch.** `RX_IN` low for 2 cycles, with `sampled_bit=1` at end of START.
  - Back in IDLE after 8 cycles.
  - No flag and no `deser_en`.
- **Back-to-back and mid-frame changes.** Two frames with the second start bit directly after the stop bit.
  - Two `data_valid` pulses, 81 cycles apart.
  - Changing `Prescale` 8→16 mid-frame leaves frame 1 at P=8 and runs frame 2 at P=16.
- **Reset mid-frame.** Assert `reset_n=0` mid-DATA.
  - All outputs are 0 immediately (asynchronously).
  - After release, the next frame is received correctly.
